mux_4to1: RTL and testbench

Parameterised 4-to-1 word multiplexer. A combinational output Y selects one of four data words D0..D3 with the 2-bit select S. A registered copy of the selected word and of the select (Y_q, S_q) is provided for pipelined consumers. The block sits in datapath steering logic, for example register-file read and ALU operand selection.

---
 rtl/mux_4to1_pkg.sv | 11 +
 rtl/mux_4to1_comb.sv | 22 ++
 rtl/mux_4to1.sv | 49 ++++
 tb/tb_mux_4to1.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mux_4to1_pkg.sv
// Shared select encodings and types for the 4-to-1 word multiplexer.
package mux_4to1_pkg;

   typedef logic [1:0] sel_t;

   localparam sel_t SEL_D0 = 2'b00;
   localparam sel_t SEL_D1 = 2'b01;
   localparam sel_t SEL_D2 = 2'b10;
   localparam sel_t SEL_D3 = 2'b11;

endpackage

// File: rtl/mux_4to1_comb.sv
// Combinational 4-to-1 word selector; an unknown select bit merges the
// candidate words bitwise instead of defaulting to any one input.
module mux_4to1_comb #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] D0,
   input  logic [WIDTH-1:0] D1,
   input  logic [WIDTH-1:0] D2,
   input  logic [WIDTH-1:0] D3,
   input  logic [1:0]       S,
   output logic [WIDTH-1:0] Y
);

   logic [WIDTH-1:0] lowPair;
   logic [WIDTH-1:0] highPair;

   // Two-level ?: tree: S[0] picks within a pair, S[1] picks the pair.
   assign lowPair  = S[0] ? D1 : D0;
   assign highPair = S[0] ? D3 : D2;
   assign Y        = S[1] ? highPair : lowPair;

endmodule

// File: rtl/mux_4to1.sv
// 4-to-1 word multiplexer with a combinational output and an enabled
// register stage holding the selected word and the select that produced it.
module mux_4to1
   import mux_4to1_pkg::*;
#(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] D0,
   input  logic [WIDTH-1:0] D1,
   input  logic [WIDTH-1:0] D2,
   input  logic [WIDTH-1:0] D3,
   input  logic [1:0]       S,
   input  logic             en,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Y_q,
   output logic [1:0]       S_q
);

   logic [WIDTH-1:0] yComb;
   sel_t             selReg;

   mux_4to1_comb #(
      .WIDTH(WIDTH)
   ) uComb (
      .D0(D0),
      .D1(D1),
      .D2(D2),
      .D3(D3),
      .S (S),
      .Y (yComb)
   );

   assign Y = yComb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Y_q    <= '0;
         selReg <= SEL_D0;
      end else if (en) begin
         Y_q    <= yComb;
         selReg <= S;
      end
   end

   assign S_q = selReg;

endmodule

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1: directed steps followed by randomized
// cycles compared against an array-indexed reference model.
module tb_mux_4to1;

   localparam int WIDTH = 5;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] D0, D1, D2, D3;
   logic [1:0]       S;
   logic             en;
   logic [WIDTH-1:0] Y;
   logic [WIDTH-1:0] Y_q;
   logic [1:0]       S_q;

   logic             clkOn = 1'b0;
   int               nChecks = 0;
   int               nFail = 0;

   mux_4to1 #(.WIDTH(WIDTH)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .D0   (D0),
      .D1   (D1),
      .D2   (D2),
      .D3   (D3),
      .S    (S),
      .en   (en),
      .Y    (Y),
      .Y_q  (Y_q),
      .S_q  (S_q)
   );

   // Clock stays undriven until the combinational-only phase is over.
   initial begin
      wait (clkOn);
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp)
      else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [WIDTH-1:0] a, b, c, d, input logic [1:0] s);
      D0 = a; D1 = b; D2 = c; D3 = d; S = s;
   endtask

   logic [WIDTH-1:0] words [4];
   logic [WIDTH-1:0] expYq;
   logic [1:0]       expSq;
   int               sel;

   initial begin
      en = 1'b0;

      // Routing of each input, clk and rst_n undriven
      words = '{5'b00001, 5'b00010, 5'b00100, 5'b01000};
      for (int i = 0; i < 4; i++) begin
         drive(words[0], words[1], words[2], words[3], 2'(i));
         #1 check($sformatf("route_s%0d", i), 32'(Y), 32'(words[i]));
      end

      // Full-width patterns in the order 11, 00, 01, 10
      words = '{5'b11111, 5'b10101, 5'b01010, 5'b00000};
      drive(words[0], words[1], words[2], words[3], 2'b11);
      #1 check("full_s3", 32'(Y), 32'(5'b00000));
      S = 2'b00; #1 check("full_s0", 32'(Y), 32'(5'b11111));
      S = 2'b01; #1 check("full_s1", 32'(Y), 32'(5'b10101));
      S = 2'b10; #1 check("full_s2", 32'(Y), 32'(5'b01010));

      // Unknown low select bit: agreeing bits must resolve
      drive(5'b0, 5'b0, 5'b10110, 5'b10110, 2'b1x);
      #1 check("xsel_agree", 32'(Y), 32'(5'b10110));
      D3 = 5'b00110;
      #1 check("xsel_lowbits", 32'(Y[3:0]), 32'(4'b0110));

      // Reset, then start the clock
      rst_n = 1'b0;
      #1 check("rst_yq", 32'(Y_q), 32'(0));
      check("rst_sq", 32'(S_q), 32'(0));
      clkOn = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      // Capture
      drive(5'b0, 5'b0, 5'b01100, 5'b0, 2'b10);
      en = 1'b1;
      @(posedge clk); #1;
      check("cap_yq", 32'(Y_q), 32'(5'b01100));
      check("cap_sq", 32'(S_q), 32'(2'b10));

      // Hold over three edges while inputs change
      @(negedge clk);
      en = 1'b0; S = 2'b01; D1 = 5'b11111;
      #1 check("hold_y", 32'(Y), 32'(5'b11111));
      repeat (3) @(posedge clk);
      #1 check("hold_yq", 32'(Y_q), 32'(5'b01100));
      check("hold_sq", 32'(S_q), 32'(2'b10));

      // Mid-cycle reset from Y_q=10101
      @(negedge clk);
      D1 = 5'b10101; en = 1'b1;
      @(posedge clk); #1;
      check("pre_rst_yq", 32'(Y_q), 32'(5'b10101));
      #2 rst_n = 1'b0;
      #1 check("midrst_yq", 32'(Y_q), 32'(0));
      check("midrst_sq", 32'(S_q), 32'(0));
      S = 2'b10; D2 = 5'b11001;
      #1 check("midrst_y", 32'(Y), 32'(5'b11001));

      // After release, no capture without en
      @(negedge clk);
      rst_n = 1'b1; en = 1'b0;
      @(posedge clk); #1;
      check("rel_noen_yq", 32'(Y_q), 32'(0));
      check("rel_noen_sq", 32'(S_q), 32'(0));

      // Randomized cycles against the reference model
      expYq = '0;
      expSq = '0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) words[k] = WIDTH'($urandom);
         sel   = int'($urandom_range(3));
         en    = 1'($urandom_range(1));
         rst_n = ($urandom_range(15) != 0);
         drive(words[0], words[1], words[2], words[3], 2'(sel));
         #1 check("rand_y", 32'(Y), 32'(words[sel]));
         if (!rst_n) begin
            expYq = '0;
            expSq = '0;
            check("rand_rst_yq", 32'(Y_q), 32'(expYq));
         end
         @(posedge clk);
         if (rst_n && en) begin
            expYq = words[sel];
            expSq = 2'(sel);
         end
         #1;
         check("rand_yq", 32'(Y_q), 32'(expYq));
         check("rand_sq", 32'(S_q), 32'(expSq));
         // Mid-cycle input changes must not reach the register
         D0 = ~D0; D1 = ~D1; D2 = ~D2; D3 = ~D3;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
